// File: rtl/axis_pkt_replay.sv
// axis_pkt_replay: replays a loaded beat table as AXI-Stream packets and counts responses.
// Define AXIS_PKT_REPLAY_CHECKSUM_EN to add the rx_csum output.
module axis_pkt_replay #(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 64,
  parameter int TBL_DEPTH      = 256,
  parameter int TIMEOUT_THRESH = 100000,
  localparam int AW = $clog2(TBL_DEPTH)
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  tbl_wr_en,
  input  logic [AW-1:0]         tbl_wr_addr,
  input  logic [DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [KEEP_WIDTH-1:0] tbl_wr_keep,
  input  logic                  tbl_wr_last,
  input  logic [AW:0]           cfg_num_beats,
  input  logic [15:0]           cfg_repeat,
  input  logic [15:0]           cfg_gap,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
`ifdef AXIS_PKT_REPLAY_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] rx_csum,
`endif
  output logic [31:0]           tx_pkt_cnt,
  output logic [31:0]           rx_pkt_cnt,
  output logic [31:0]           rx_beat_cnt
);

  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_RX, DONE} state_e;

  state_e                state_q, state_d;
  logic [EW-1:0]         mem [TBL_DEPTH];
  logic [EW-1:0]         rd_q;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           num_q, num_d;
  logic [15:0]           pass_q, pass_d, gap_q, gap_d;
  logic [15:0]           gap_cnt_q, gap_cnt_d;
  logic                  issued_q, issued_d;
  logic                  p_vld_q, p_vld_d, p_end_q, p_end_d;
  logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  to_q, to_d, rdy_q;
  logic [31:0]           tx_pkt_q, tx_pkt_d, rx_pkt_q, rx_pkt_d;
  logic [31:0]           rx_beat_q, rx_beat_d, idle_q, idle_d;
  logic                  rd_en, tbl_we, s_hs, go, o_load;
  logic                  out_fire, tlast_fire, final_beat, sending;
  logic                  unused_in;

  assign tbl_we = tbl_wr_en & (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (tbl_we) mem[tbl_wr_addr] <= {tbl_wr_last, tbl_wr_keep, tbl_wr_data};
    if (rd_en) rd_q <= mem[rd_ptr_q];
  end

  assign s_hs       = s_axis_tvalid & rdy_q;
  assign out_fire   = m_valid_q & m_axis_tready;
  assign tlast_fire = out_fire & m_last_q;
  assign go         = start & (state_q == IDLE || state_q == DONE);
  assign final_beat = issued_q & ~p_vld_q;
  assign sending    = state_q == SEND || state_q == GAP;

  // The prefetched beat moves to the output slot when it frees up,
  // except right after a tlast that opens a gap.
  assign o_load = p_vld_q & (
      ((state_q == SEND) & (~m_valid_q | out_fire) & ~(tlast_fire & (|gap_q)))
    | ((state_q == GAP) & (gap_cnt_q == 16'd1)));
  assign rd_en = sending & ~issued_q & (~p_vld_q | o_load);

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    num_d     = num_q;
    pass_d    = pass_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    issued_d  = issued_q;
    p_vld_d   = p_vld_q;
    p_end_d   = p_end_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    done_d    = done_q;
    to_d      = to_q;
    tx_pkt_d  = tx_pkt_q;
    rx_pkt_d  = rx_pkt_q;
    rx_beat_d = rx_beat_q;
    idle_d    = '0;

    if (rd_en) begin
      p_vld_d = 1'b1;
      p_end_d = {1'b0, rd_ptr_q} == num_q - 1'b1;
      if (p_end_d) begin
        rd_ptr_d = '0;
        if (pass_q == 16'd1) issued_d = 1'b1;
        else pass_d = pass_q - 16'd1;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end else if (o_load) begin
      p_vld_d = 1'b0;
    end

    if (o_load) begin
      m_valid_d = 1'b1;
      m_data_d  = rd_q[DATA_WIDTH-1:0];
      m_keep_d  = rd_q[DATA_WIDTH +: KEEP_WIDTH];
      m_last_d  = rd_q[EW-1] | p_end_q;
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end

    if (tlast_fire) tx_pkt_d = tx_pkt_q + 32'd1;
    if (s_hs) begin
      rx_beat_d = rx_beat_q + 32'd1;
      if (s_axis_tlast) rx_pkt_d = rx_pkt_q + 32'd1;
    end

    case (state_q)
      SEND: begin
        if (tlast_fire) begin
          if (|gap_q) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
          end else if (final_beat) begin
            state_d = WAIT_RX;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'd1) state_d = final_beat ? WAIT_RX : SEND;
        else gap_cnt_d = gap_cnt_q - 16'd1;
      end
      WAIT_RX: begin
        idle_d = s_hs ? '0 : idle_q + 32'd1;
        if (rx_pkt_q >= tx_pkt_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!s_hs && idle_q + 32'd1 == 32'(TIMEOUT_THRESH)) begin
          state_d = DONE;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end
      end
      default: ;
    endcase

    if (go) begin
      num_d     = cfg_num_beats;
      pass_d    = (cfg_repeat == 16'd0) ? 16'd1 : cfg_repeat;
      gap_d     = cfg_gap;
      rd_ptr_d  = '0;
      issued_d  = 1'b0;
      p_vld_d   = 1'b0;
      tx_pkt_d  = '0;
      rx_pkt_d  = '0;
      rx_beat_d = '0;
      to_d      = 1'b0;
      done_d    = cfg_num_beats == '0;
      state_d   = (cfg_num_beats == '0) ? DONE : SEND;
    end

    busy_d = state_d == SEND || state_d == GAP || state_d == WAIT_RX;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      num_q     <= '0;
      pass_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      issued_q  <= 1'b0;
      p_vld_q   <= 1'b0;
      p_end_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      rdy_q     <= 1'b0;
      tx_pkt_q  <= '0;
      rx_pkt_q  <= '0;
      rx_beat_q <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      num_q     <= num_d;
      pass_q    <= pass_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      issued_q  <= issued_d;
      p_vld_q   <= p_vld_d;
      p_end_q   <= p_end_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_q      <= to_d;
      rdy_q     <= 1'b1;
      tx_pkt_q  <= tx_pkt_d;
      rx_pkt_q  <= rx_pkt_d;
      rx_beat_q <= rx_beat_d;
      idle_q    <= idle_d;
    end
  end

`ifdef AXIS_PKT_REPLAY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d, kmask;

  always_comb begin
    kmask = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) kmask[b*8 +: 8] = {8{s_axis_tkeep[b]}};
    csum_d = csum_q;
    if (go) csum_d = '0;
    else if (s_hs) csum_d = csum_q ^ (s_axis_tdata & kmask);
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign rx_csum   = csum_q;
  assign unused_in = ^s_axis_tuser;
`else
  assign unused_in = ^{s_axis_tdata, s_axis_tkeep, s_axis_tuser};
`endif

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = '0;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign s_axis_tready = rdy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timed_out     = to_q;
  assign tx_pkt_cnt    = tx_pkt_q;
  assign rx_pkt_cnt    = rx_pkt_q;
  assign rx_beat_cnt   = rx_beat_q;

endmodule

// File: tb/tb_axis_pkt_replay.sv
// tb_axis_pkt_replay: directed table-driven bench for axis_pkt_replay.
// Covers replay, stalls, gaps, timeout, empty table and mid-run reset.
module tb_axis_pkt_replay;
  localparam int DW = 64, KW = 8, UW = 64, DEPTH = 16, AW = 4, THR = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst, tbl_wr_en, tbl_wr_last, start;
  logic [AW-1:0] tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic [KW-1:0] tbl_wr_keep;
  logic [AW:0]   cfg_num_beats;
  logic [15:0]   cfg_repeat, cfg_gap;
  logic [DW-1:0] m_axis_tdata, s_axis_tdata;
  logic [KW-1:0] m_axis_tkeep, s_axis_tkeep;
  logic [UW-1:0] m_axis_tuser, s_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          busy, done, timed_out;
  logic [31:0]   tx_pkt_cnt, rx_pkt_cnt, rx_beat_cnt;
`ifdef AXIS_PKT_REPLAY_CHECKSUM_EN
  logic [DW-1:0] rx_csum;
`endif

  logic lb, rnd;
  assign s_axis_tvalid = lb & m_axis_tvalid & m_axis_tready;
  assign s_axis_tdata  = m_axis_tdata;
  assign s_axis_tkeep  = m_axis_tkeep;
  assign s_axis_tlast  = m_axis_tlast;
  assign s_axis_tuser  = '0;

  axis_pkt_replay #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .TBL_DEPTH(DEPTH), .TIMEOUT_THRESH(THR)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .tbl_wr_keep(tbl_wr_keep),
    .tbl_wr_last(tbl_wr_last),
    .cfg_num_beats(cfg_num_beats), .cfg_repeat(cfg_repeat),
    .cfg_gap(cfg_gap), .start(start),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .busy(busy), .done(done), .timed_out(timed_out),
`ifdef AXIS_PKT_REPLAY_CHECKSUM_EN
    .rx_csum(rx_csum),
`endif
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt),
    .rx_beat_cnt(rx_beat_cnt)
  );

  int n_chk = 0, n_pass = 0, cyc = 0, vcnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Transmit monitor: records accepted beats, checks hold-while-stalled.
  logic [63:0] txd_q[$];
  bit          txl_q[$];
  int          txc_q[$];
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [63:0] pd = '0;

  always @(negedge clk) begin
    if (!sys_rst) begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", m_axis_tdata, pd);
        chk("stall_last", 64'(m_axis_tlast), 64'(pl));
      end
      if (m_axis_tvalid) vcnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        txd_q.push_back(m_axis_tdata);
        txl_q.push_back(m_axis_tlast);
        txc_q.push_back(cyc);
      end
    end
    pv = m_axis_tvalid & ~sys_rst;
    pr = m_axis_tready;
    pd = m_axis_tdata;
    pl = m_axis_tlast;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input logic [3:0] lmask);
    for (int i = 0; i < 4; i++) begin
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = AW'(i);
      tbl_wr_data = 64'(i);
      tbl_wr_keep = '1;
      tbl_wr_last = lmask[i];
      tick();
    end
    tbl_wr_en = 1'b0;
  endtask

  task automatic run(input int num, input int rep, input int gap,
                     input int budget, output int dcyc);
    int i;
    txd_q.delete();
    txl_q.delete();
    txc_q.delete();
    cfg_num_beats = (AW+1)'(num);
    cfg_repeat    = 16'(rep);
    cfg_gap       = 16'(gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (!done && i < budget) begin
      tick();
      i++;
    end
    dcyc = cyc;
    if (!done) chk("run_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_seq(input int num, input int rep,
                           input logic [3:0] lmask);
    int np, k;
    bit el;
    np = (rep == 0) ? 1 : rep;
    k = 0;
    chk("beat_count", 64'(txd_q.size()), 64'(np * num));
    for (int p = 0; p < np; p++)
      for (int i = 0; i < num; i++) begin
        el = lmask[i] | (i == num - 1);
        if (k < txd_q.size()) begin
          chk("seq_data", txd_q[k], 64'(i));
          chk("seq_last", 64'(txl_q[k]), 64'(el));
        end
        k++;
      end
  endtask

  typedef struct {
    int         num;
    int         rep;
    int         gap;
    bit         lb;
    logic [3:0] lmask;
    int         e_txp;
    int         e_rxp;
    int         e_rxb;
    bit         e_to;
  } vec_t;

  vec_t vecs[5];
  int   dc, s0;

  initial begin
    vecs[0] = '{3, 2, 0, 1'b1, 4'b0100, 2, 2, 6, 1'b0};
    vecs[1] = '{4, 1, 0, 1'b1, 4'b0010, 2, 2, 4, 1'b0};
    vecs[2] = '{4, 3, 2, 1'b1, 4'b0010, 6, 6, 12, 1'b0};
    vecs[3] = '{1, 0, 0, 1'b1, 4'b0000, 1, 1, 1, 1'b0};
    vecs[4] = '{2, 2, 0, 1'b0, 4'b0000, 2, 0, 0, 1'b1};

    sys_rst = 1'b1; lb = 1'b1; rnd = 1'b0; start = 1'b0;
    m_axis_tready = 1'b1;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    tbl_wr_keep = '0; tbl_wr_last = 1'b0;
    cfg_num_beats = '0; cfg_repeat = '0; cfg_gap = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_to", 64'(timed_out), 64'd0);
    chk("rst_txp", 64'(tx_pkt_cnt), 64'd0);
    chk("rst_rxp", 64'(rx_pkt_cnt), 64'd0);
    chk("rst_rxb", 64'(rx_beat_cnt), 64'd0);
    chk("rst_sready", 64'(s_axis_tready), 64'd0);
    sys_rst = 1'b0;
    tick();
    chk("post_rst_sready", 64'(s_axis_tready), 64'd1);

    for (int r = 0; r < 5; r++) begin
      lb = vecs[r].lb;
      load(vecs[r].lmask);
      run(vecs[r].num, vecs[r].rep, vecs[r].gap, 400, dc);
      chk("row_txp", 64'(tx_pkt_cnt), 64'(vecs[r].e_txp));
      chk("row_rxp", 64'(rx_pkt_cnt), 64'(vecs[r].e_rxp));
      chk("row_rxb", 64'(rx_beat_cnt), 64'(vecs[r].e_rxb));
      chk("row_to", 64'(timed_out), 64'(vecs[r].e_to));
      chk("row_done", 64'(done), 64'd1);
      chk("row_busy", 64'(busy), 64'd0);
      chk("row_tuser", m_axis_tuser, 64'd0);
      check_seq(vecs[r].num, vecs[r].rep, vecs[r].lmask);
    end

    // random backpressure
    lb = 1'b1;
    load(4'b0000);
    rnd = 1'b1;
    run(4, 1, 0, 400, dc);
    rnd = 1'b0;
    m_axis_tready = 1'b1;
    check_seq(4, 1, 4'b0000);
    chk("stall_rxp", 64'(rx_pkt_cnt), 64'd1);

    // gap of 5 between two single-beat packets
    load(4'b0001);
    run(1, 2, 5, 200, dc);
    chk("gap_beats", 64'(txd_q.size()), 64'd2);
    if (txd_q.size() == 2)
      chk("gap_spacing", 64'(txc_q[1] - txc_q[0]), 64'd6);

    // timeout exactly THR cycles after the last accepted beat
    lb = 1'b0;
    load(4'b0000);
    run(1, 1, 0, 400, dc);
    chk("to_flag", 64'(timed_out), 64'd1);
    chk("to_txp", 64'(tx_pkt_cnt), 64'd1);
    chk("to_rxp", 64'(rx_pkt_cnt), 64'd0);
    chk("to_beats", 64'(txd_q.size()), 64'd1);
    if (txd_q.size() == 1)
      chk("to_latency", 64'(dc - (txc_q[0] + 1)), 64'(THR));

    // empty table
    lb = 1'b1;
    vcnt = 0;
    s0 = cyc;
    run(0, 1, 0, 10, dc);
    chk("empty_done_cyc", 64'(dc), 64'(s0 + 1));
    chk("empty_done", 64'(done), 64'd1);
    repeat (3) tick();
    chk("empty_txp", 64'(tx_pkt_cnt), 64'd0);
    chk("empty_vcnt", 64'(vcnt), 64'd0);
    chk("empty_busy", 64'(busy), 64'd0);

    // start latency, then reset mid-SEND
    cfg_num_beats = 5'd4; cfg_repeat = 16'd3; cfg_gap = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lat_n1", 64'(m_axis_tvalid), 64'd0);
    tick();
    chk("lat_n2", 64'(m_axis_tvalid), 64'd1);
    chk("lat_data", m_axis_tdata, 64'd0);
    repeat (2) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    #3 sys_rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_sready", 64'(s_axis_tready), 64'd0);
    chk("arst_txp", 64'(tx_pkt_cnt), 64'd0);
    @(posedge clk);
    #1 sys_rst = 1'b0;
    tick();
    chk("rel_sready", 64'(s_axis_tready), 64'd1);
    chk("rel_done", 64'(done), 64'd0);
    run(4, 1, 0, 100, dc);
    check_seq(4, 1, 4'b0000);
    chk("rel_txp", 64'(tx_pkt_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
